// File: rtl/axi_sram_responder.sv
// AXI slave responder: serves one AXI read or write burst at a time from a
// single-port synchronous SRAM with one cycle of read latency. Reads run
// through a two-entry output FIFO with one SRAM read in flight.
module axi_sram_responder #(
    parameter int BW_ADDR      = 32,
    parameter int BW_DATA      = 32,
    parameter int BW_AXI_TID   = 1,
    parameter int BW_SRAM_ADDR = 10
) (
    input  logic                    clk,
    input  logic                    rstnn,
    // write address channel
    input  logic [BW_AXI_TID-1:0]   rxawid,
    input  logic [BW_ADDR-1:0]      rxawaddr,
    input  logic [7:0]              rxawlen,
    input  logic [2:0]              rxawsize,
    input  logic [1:0]              rxawburst,
    input  logic                    rxawvalid,
    output logic                    rxawready,
    // write data channel
    input  logic [BW_AXI_TID-1:0]   rxwid,
    input  logic [BW_DATA-1:0]      rxwdata,
    input  logic [BW_DATA/8-1:0]    rxwstrb,
    input  logic                    rxwlast,
    input  logic                    rxwvalid,
    output logic                    rxwready,
    // write response channel
    output logic [BW_AXI_TID-1:0]   rxbid,
    output logic [1:0]              rxbresp,
    output logic                    rxbvalid,
    input  logic                    rxbready,
    // read address channel
    input  logic [BW_AXI_TID-1:0]   rxarid,
    input  logic [BW_ADDR-1:0]      rxaraddr,
    input  logic [7:0]              rxarlen,
    input  logic [2:0]              rxarsize,
    input  logic [1:0]              rxarburst,
    input  logic                    rxarvalid,
    output logic                    rxarready,
    // read data channel
    output logic [BW_AXI_TID-1:0]   rxrid,
    output logic [BW_DATA-1:0]      rxrdata,
    output logic [1:0]              rxrresp,
    output logic                    rxrlast,
    output logic                    rxrvalid,
    input  logic                    rxrready,
    // SRAM port
    output logic                    sram_select,
    output logic                    sram_wenable,
    output logic [BW_SRAM_ADDR-1:0] sram_addr,
    output logic [BW_DATA-1:0]      sram_wdata,
    output logic [BW_DATA/8-1:0]    sram_byteenable,
    input  logic [BW_DATA-1:0]      sram_rdata
);

    localparam int         LG_STRB     = $clog2(BW_DATA / 8);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic                    prefer_read_q, prefer_read_d;
    logic [BW_AXI_TID-1:0]   id_q, id_d;
    logic [BW_ADDR-1:0]      addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [8:0]              beat_q, beat_d;
    logic                    addr_err_q, addr_err_d;
    logic                    wlast_err_q, wlast_err_d;
    logic [BW_DATA-1:0]      fifo_data_q [2];
    logic [BW_DATA-1:0]      fifo_data_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    fifo_head_q, fifo_head_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;

    logic grant_rd, grant_wr;
    logic last_beat, issue_rd;
    logic fifo_nonempty, fifo_tail, push, pop_fifo, r_hs;
    logic unused_bits;

    // Next beat address for FIXED / INCR / WRAP; the reserved type advances like INCR.
    function automatic logic [BW_ADDR-1:0] next_addr(
        input logic [BW_ADDR-1:0] addr,
        input logic [7:0]         len,
        input logic [2:0]         size,
        input logic [1:0]         burst
    );
        logic [BW_ADDR-1:0] step, incr, window;
        step   = BW_ADDR'(1) << size;
        incr   = addr + step;
        window = BW_ADDR'({1'b0, len} + 9'd1) << size;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~(window - 1'b1)) | (incr & (window - 1'b1));
            default:     next_addr = incr;
        endcase
    endfunction

    // Reserved burst type or a beat wider than the data bus cannot be served.
    function automatic logic bad_request(input logic [1:0] burst, input logic [2:0] size);
        bad_request = (burst == BURST_RSVD) || (size > 3'(LG_STRB));
    endfunction

    assign last_beat     = (beat_q == {1'b0, len_q});
    assign fifo_nonempty = (fifo_cnt_q != 2'd0);
    assign fifo_tail     = fifo_head_q ^ fifo_cnt_q[0];
    assign issue_rd      = (state_q == S_READ) && ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2);

    // Empty FIFO lets the in-flight SRAM word fall through, giving N+2 latency.
    assign rxrvalid = fifo_nonempty | inflight_q;
    assign rxrdata  = fifo_nonempty ? fifo_data_q[fifo_head_q] : sram_rdata;
    assign rxrlast  = fifo_nonempty ? fifo_last_q[fifo_head_q] : inflight_last_q;
    assign rxrid    = id_q;
    assign rxrresp  = addr_err_q ? RESP_SLVERR : RESP_OKAY;
    assign r_hs     = rxrvalid & rxrready;
    assign pop_fifo = fifo_nonempty & rxrready;
    // The arriving word is parked unless it bypasses straight into a handshake.
    assign push     = inflight_q & (fifo_nonempty | ~rxrready);

    assign rxbid   = id_q;
    assign rxbresp = (addr_err_q | wlast_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign sram_addr       = addr_q[LG_STRB +: BW_SRAM_ADDR];
    assign sram_wdata      = rxwdata;
    assign sram_byteenable = rxwstrb;

    // AXI4 carries no write ID on the W channel; it is accepted and ignored.
    assign unused_bits = ^rxwid;

    // Transaction FSM: address arbitration, beat sequencing and SRAM strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d       = state_q;
        prefer_read_d = prefer_read_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        burst_d       = burst_q;
        beat_d        = beat_q;
        addr_err_d    = addr_err_q;
        wlast_err_d   = wlast_err_q;
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;
        rxawready     = 1'b0;
        rxarready     = 1'b0;
        rxwready      = 1'b0;
        rxbvalid      = 1'b0;
        sram_select   = 1'b0;
        sram_wenable  = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_rd  = rxarvalid & (~rxawvalid | prefer_read_q);
                grant_wr  = rxawvalid & ~grant_rd;
                rxarready = grant_rd;
                rxawready = grant_wr;
                if (grant_rd) begin
                    id_d          = rxarid;
                    addr_d        = rxaraddr;
                    len_d         = rxarlen;
                    size_d        = rxarsize;
                    burst_d       = rxarburst;
                    addr_err_d    = bad_request(rxarburst, rxarsize);
                    wlast_err_d   = 1'b0;
                    beat_d        = 9'd0;
                    prefer_read_d = 1'b0;
                    state_d       = S_READ;
                end else if (grant_wr) begin
                    id_d          = rxawid;
                    addr_d        = rxawaddr;
                    len_d         = rxawlen;
                    size_d        = rxawsize;
                    burst_d       = rxawburst;
                    addr_err_d    = bad_request(rxawburst, rxawsize);
                    wlast_err_d   = 1'b0;
                    beat_d        = 9'd0;
                    prefer_read_d = 1'b1;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                rxwready = 1'b1;
                if (rxwvalid) begin
                    sram_select  = ~addr_err_q;
                    sram_wenable = 1'b1;
                    addr_d       = next_addr(addr_q, len_q, size_q, burst_q);
                    beat_d       = beat_q + 9'd1;
                    // Length comes from AWLEN; WLAST is only cross-checked.
                    if (last_beat) begin
                        wlast_err_d = wlast_err_q | ~rxwlast;
                        state_d     = S_WRESP;
                    end else begin
                        wlast_err_d = wlast_err_q | rxwlast;
                    end
                end
            end
            S_WRESP: begin
                rxbvalid = 1'b1;
                if (rxbready) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_rd) begin
                    sram_select = ~addr_err_q;
                    addr_d      = next_addr(addr_q, len_q, size_q, burst_q);
                    beat_d      = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = S_RDRAIN;
                    end
                end
            end
            S_RDRAIN: begin
                if (r_hs && rxrlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-return FIFO bookkeeping and the single in-flight SRAM read.
    always_comb begin
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        fifo_head_d     = fifo_head_q ^ pop_fifo;
        fifo_cnt_d      = fifo_cnt_q + {1'b0, push} - {1'b0, pop_fifo};
        inflight_d      = issue_rd;
        inflight_last_d = issue_rd & last_beat;
        if (push) begin
            fifo_data_d[fifo_tail] = sram_rdata;
            fifo_last_d[fifo_tail] = inflight_last_q;
        end
    end

    // State registers; reset aborts any burst, flushes the FIFO and drops the in-flight read.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q         <= S_IDLE;
            prefer_read_q   <= 1'b1;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            beat_q          <= '0;
            addr_err_q      <= 1'b0;
            wlast_err_q     <= 1'b0;
            // NOTE: the FIFO is only two flops deep, so it is reset rather than left as RAM.
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            fifo_head_q     <= 1'b0;
            fifo_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q         <= state_d;
            prefer_read_q   <= prefer_read_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            size_q          <= size_d;
            burst_q         <= burst_d;
            beat_q          <= beat_d;
            addr_err_q      <= addr_err_d;
            wlast_err_q     <= wlast_err_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            fifo_head_q     <= fifo_head_d;
            fifo_cnt_q      <= fifo_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a behavioural SRAM model.
module tb_axi_sram_responder;

    localparam int BW_ADDR      = 32;
    localparam int BW_DATA      = 32;
    localparam int BW_AXI_TID   = 1;
    localparam int BW_SRAM_ADDR = 10;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] RSVD   = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                    clk = 1'b0;
    logic                    rstnn = 1'b0;
    logic [BW_AXI_TID-1:0]   rxawid, rxwid, rxbid, rxarid, rxrid;
    logic [BW_ADDR-1:0]      rxawaddr, rxaraddr;
    logic [7:0]              rxawlen, rxarlen;
    logic [2:0]              rxawsize, rxarsize;
    logic [1:0]              rxawburst, rxarburst, rxbresp, rxrresp;
    logic                    rxawvalid, rxawready, rxwlast, rxwvalid, rxwready;
    logic                    rxbvalid, rxbready, rxarvalid, rxarready;
    logic                    rxrlast, rxrvalid, rxrready;
    logic [BW_DATA-1:0]      rxwdata, rxrdata, sram_wdata, sram_rdata;
    logic [BW_DATA/8-1:0]    rxwstrb, sram_byteenable;
    logic                    sram_select, sram_wenable;
    logic [BW_SRAM_ADDR-1:0] sram_addr;

    axi_sram_responder #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA),
        .BW_AXI_TID(BW_AXI_TID), .BW_SRAM_ADDR(BW_SRAM_ADDR)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .rxawid(rxawid), .rxawaddr(rxawaddr), .rxawlen(rxawlen), .rxawsize(rxawsize),
        .rxawburst(rxawburst), .rxawvalid(rxawvalid), .rxawready(rxawready),
        .rxwid(rxwid), .rxwdata(rxwdata), .rxwstrb(rxwstrb), .rxwlast(rxwlast),
        .rxwvalid(rxwvalid), .rxwready(rxwready),
        .rxbid(rxbid), .rxbresp(rxbresp), .rxbvalid(rxbvalid), .rxbready(rxbready),
        .rxarid(rxarid), .rxaraddr(rxaraddr), .rxarlen(rxarlen), .rxarsize(rxarsize),
        .rxarburst(rxarburst), .rxarvalid(rxarvalid), .rxarready(rxarready),
        .rxrid(rxrid), .rxrdata(rxrdata), .rxrresp(rxrresp), .rxrlast(rxrlast),
        .rxrvalid(rxrvalid), .rxrready(rxrready),
        .sram_select(sram_select), .sram_wenable(sram_wenable), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_byteenable(sram_byteenable), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: word i preloads to 0xA000_0000 + i; reads return one cycle later.
    logic [BW_DATA-1:0] mem [0:1023];
    logic               preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (sram_select) begin
            if (sram_wenable) begin
                for (int b = 0; b < 4; b++)
                    if (sram_byteenable[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_v [0:15];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int k = 0;
        rxawid = id; rxawaddr = addr; rxawlen = len; rxawsize = 3'd2; rxawburst = burst;
        rxawvalid = 1'b1;
        #1;
        while (!rxawready && k < 20) begin @(negedge clk); #1; k++; end
        check("aw_accept", rxawready, 1'b1);
        @(negedge clk);
        rxawvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats, input int last_at, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_sel, input logic [9:0] word);
        for (int i = 0; i < nbeats; i++) begin
            rxwvalid = 1'b1; rxwdata = data + i; rxwstrb = strb; rxwlast = (i == last_at);
            #1;
            check("w_ready", rxwready, 1'b1);
            check("w_select", sram_select, exp_sel);
            if (exp_sel) begin
                check("w_wenable", sram_wenable, 1'b1);
                check("w_addr", sram_addr, 10'(word + i));
                check("w_data", {sram_byteenable, sram_wdata}, {strb, data + i});
            end
            @(negedge clk);
        end
        rxwvalid = 1'b0; rxwlast = 1'b0;
    endtask

    // Holds B off for one cycle, then accepts it; returns just after the IDLE cycle begins.
    task automatic recv_b(input logic id, input logic [1:0] resp);
        int k = 0;
        #1;
        while (!rxbvalid && k < 20) begin @(negedge clk); #1; k++; end
        check("b_valid", rxbvalid, 1'b1);
        check("b_id_resp", {rxbid, rxbresp}, {id, resp});
        @(negedge clk); #1;
        check("b_hold", {rxbvalid, rxbid, rxbresp}, {1'b1, id, resp});
        rxbready = 1'b1;
        @(negedge clk);
        rxbready = 1'b0;
        #1;
        check("b_done", rxbvalid, 1'b0);
    endtask

    // Reads a size-2 burst, compares against exp_v; rpat[k%4] gives rxrready per cycle.
    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] rpat, input string tag);
        int k = 0, beat = 0, hs_cyc, first_cyc = -1, issued = 0, consumed = 0, max_out = 0;
        logic held = 1'b0;
        logic [31:0] held_data = '0;
        rxarid = id; rxaraddr = addr; rxarlen = len; rxarsize = 3'd2; rxarburst = burst;
        rxarvalid = 1'b1;
        #1;
        while (!rxarready && k < 20) begin @(negedge clk); #1; k++; end
        check({tag, "_ar_accept"}, rxarready, 1'b1);
        hs_cyc = cyc;
        @(negedge clk);
        rxarvalid = 1'b0;
        k = 0;
        while (beat <= int'(len) && k < 200) begin
            rxrready = rpat[k % 4];
            #1;
            if (sram_select && !sram_wenable) issued++;
            if (rxrvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held) check({tag, "_stable"}, rxrdata, held_data);
                if (rxrready) begin
                    check({tag, "_data"}, rxrdata, exp_v[beat]);
                    check({tag, "_last"}, rxrlast, (beat == int'(len)));
                    check({tag, "_id_resp"}, {rxrid, rxrresp}, {id, OKAY});
                    beat++; consumed++; held = 1'b0;
                end else begin
                    held = 1'b1; held_data = rxrdata;
                end
            end
            if (issued - consumed > max_out) max_out = issued - consumed;
            @(negedge clk);
            k++;
        end
        rxrready = 1'b0;
        check({tag, "_beats"}, beat, int'(len) + 1);
        check({tag, "_latency"}, first_cyc - hs_cyc, 2);
        check({tag, "_outstanding"}, (max_out <= 2), 1'b1);
        #1;
        check({tag, "_rvalid_after"}, rxrvalid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        logic seen;
        rxawid = '0; rxawaddr = '0; rxawlen = '0; rxawsize = '0; rxawburst = '0; rxawvalid = 1'b0;
        rxwid = '0; rxwdata = '0; rxwstrb = '0; rxwlast = 1'b0; rxwvalid = 1'b0; rxbready = 1'b0;
        rxarid = '0; rxaraddr = '0; rxarlen = '0; rxarsize = '0; rxarburst = '0; rxarvalid = 1'b0;
        rxrready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {rxawready, rxarready, rxwready, rxbvalid, rxrvalid, sram_select}, 6'b0);
        @(negedge clk);
        preload = 1'b0;
        rstnn   = 1'b1;
        @(negedge clk);

        // Single full-word write to word 4
        send_aw(1'b1, 32'h10, 8'd0, INCR);
        send_w(1, 0, 32'hDEAD_BEEF, 4'hF, 1'b1, 10'd4);
        recv_b(1'b1, OKAY);
        @(negedge clk);
        check("mem_word4", mem[4], 32'hDEAD_BEEF);

        // Partial-strobe write to word 9: bytes 0 and 2 replaced
        send_aw(1'b0, 32'h24, 8'd0, INCR);
        send_w(1, 0, 32'h1122_3344, 4'b0101, 1'b1, 10'd9);
        recv_b(1'b0, OKAY);
        @(negedge clk);
        check("mem_word9", mem[9], 32'hA022_0044);

        // INCR read of words 4..7, then the same read under backpressure
        exp_v[0] = 32'hDEAD_BEEF; exp_v[1] = 32'hA000_0005;
        exp_v[2] = 32'hA000_0006; exp_v[3] = 32'hA000_0007;
        do_read(1'b1, 32'h10, 8'd3, INCR, 4'b1111, "incr");
        do_read(1'b1, 32'h10, 8'd3, INCR, 4'b1001, "bp");

        // WRAP read from 0x18 returns words 6, 7, 4, 5
        exp_v[0] = 32'hA000_0006; exp_v[1] = 32'hA000_0007;
        exp_v[2] = 32'hDEAD_BEEF; exp_v[3] = 32'hA000_0005;
        do_read(1'b0, 32'h18, 8'd3, WRAP, 4'b1111, "wrap");

        // Reserved burst type: no SRAM strobe, SLVERR, memory untouched
        send_aw(1'b1, 32'h30, 8'd0, RSVD);
        send_w(1, 0, 32'hBAD0_BAD0, 4'hF, 1'b0, 10'd12);
        recv_b(1'b1, SLVERR);
        @(negedge clk);
        check("mem_word12", mem[12], 32'hA000_000C);

        // WLAST on the first of two beats: both beats written, SLVERR
        send_aw(1'b0, 32'h38, 8'd1, INCR);
        send_w(2, 0, 32'h7777_0000, 4'hF, 1'b1, 10'd14);
        recv_b(1'b0, SLVERR);
        @(negedge clk);

        // WLAST never asserted on a single-beat burst: SLVERR
        send_aw(1'b1, 32'h3C, 8'd0, INCR);
        send_w(1, 99, 32'h6666_0000, 4'hF, 1'b1, 10'd15);
        recv_b(1'b1, SLVERR);
        @(negedge clk);

        // Reset in the middle of a stalled read burst
        rxarid = 1'b0; rxaraddr = 32'h0; rxarlen = 8'd7; rxarsize = 3'd2; rxarburst = INCR;
        rxarvalid = 1'b1; rxrready = 1'b0;
        #1;
        check("mid_ar_accept", rxarready, 1'b1);
        @(negedge clk);
        rxarvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_rvalid_before", rxrvalid, 1'b1);
        rstnn = 1'b0;
        #1;
        check("mid_reset_outputs", {rxrvalid, rxbvalid, rxawready, rxarready, rxwready, sram_select}, 6'b0);
        @(negedge clk);
        rstnn = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); #1; seen |= rxrvalid; end
        check("mid_no_response", seen, 1'b0);
        @(negedge clk);

        // Arbitration: both valid twice; reset pointer grants read first, then write
        rxawid = 1'b1; rxawaddr = 32'h40; rxawlen = 8'd0; rxawsize = 3'd2; rxawburst = INCR;
        rxawvalid = 1'b1;
        rxarid = 1'b0; rxaraddr = 32'h20; rxarlen = 8'd0; rxarsize = 3'd2; rxarburst = INCR;
        rxarvalid = 1'b1;
        #1;
        check("arb_first", {rxarready, rxawready}, 2'b10);
        @(negedge clk);
        rxarvalid = 1'b0; rxrready = 1'b1;
        #1;
        check("arb_aw_waits", rxawready, 1'b0);
        k = 0;
        while (!rxrvalid && k < 20) begin @(negedge clk); #1; k++; end
        check("arb_rd_beat", {rxrvalid, rxrlast, rxrdata}, {1'b1, 1'b1, 32'hA000_0008});
        @(negedge clk);
        rxrready = 1'b0;
        rxaraddr = 32'h40; rxarvalid = 1'b1;
        #1;
        check("arb_second", {rxarready, rxawready}, 2'b01);
        @(negedge clk);
        rxawvalid = 1'b0;
        send_w(1, 0, 32'h55AA_55AA, 4'hF, 1'b1, 10'd16);
        recv_b(1'b1, OKAY);
        exp_v[0] = 32'h55AA_55AA;
        do_read(1'b0, 32'h40, 8'd0, INCR, 4'b1111, "arb_rd2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI slave responder: accepts AXI read/write bursts and serves them from a single-port synchronous SRAM with 1-cycle read latency.
- Counterpart of the cache-side AXI master. Used as the on-chip memory target behind the interconnect and as the bench target for cache masters.
- Serves one transaction at a time; reads and writes never overlap.

Parameters:
- BW_ADDR, 32, AXI address width.
- BW_DATA, 32, AXI/SRAM data width; power of two, 32 or more.
- BW_AXI_TID, 1, AXI ID width.
- BW_SRAM_ADDR, 10, SRAM word-address width; sram_addr = axi_addr[BW_SRAM_ADDR+log2(BW_DATA/8)-1 : log2(BW_DATA/8)].

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- rxawid/rxawaddr/rxawlen/rxawsize/rxawburst  in  BW_AXI_TID/BW_ADDR/8/3/2  AW payload
- rxawvalid in 1, rxawready out 1  AW handshake
- rxwid/rxwdata/rxwstrb/rxwlast  in  BW_AXI_TID/BW_DATA/BW_DATA/8/1  W payload
- rxwvalid in 1, rxwready out 1  W handshake
- rxbid/rxbresp  out  BW_AXI_TID/2  B payload
- rxbvalid out 1, rxbready in 1  B handshake
- rxarid/rxaraddr/rxarlen/rxarsize/rxarburst  in  BW_AXI_TID/BW_ADDR/8/3/2  AR payload
- rxarvalid in 1, rxarready out 1  AR handshake
- rxrid/rxrdata/rxrresp/rxrlast  out  BW_AXI_TID/BW_DATA/2/1  R payload
- rxrvalid out 1, rxrready in 1  R handshake
- sram_select  out  1  SRAM access strobe
- sram_wenable  out  1  1 = write, 0 = read
- sram_addr  out  BW_SRAM_ADDR  word address
- sram_wdata/sram_byteenable  out  BW_DATA/BW_DATA/8  write data and byte enables
- sram_rdata  in  BW_DATA  read data, valid the cycle after a read select

Behaviour:
- Reset: all valid/ready outputs 0, sram_select 0, FSM in IDLE, arbitration pointer set to read, buffer empty, all payload registers 0.
- FSM states: IDLE, WRITE, WRESP, READ, RDRAIN.
- IDLE: rxawready and rxarready are combinational.
  - Only one valid asserted: that channel's ready = 1.
  - Both valid: grant the channel not served last (round-robin pointer, toggled on each accepted address).
  - On accept: latch id, addr, len, size, burst; beat counter = 0.
  - Writes go to WRITE; reads go to READ.
- Address generation, per beat:
  - FIXED: address unchanged.
  - INCR: add 2^size.
  - WRAP: add 2^size, wrapping within an aligned window of (len+1)*2^size bytes.
  - Burst type 2'b11 or size > log2(BW_DATA/8): flag error. Beats still complete but sram_select is held 0; resp = SLVERR (2'b10). Otherwise resp = OKAY.
- WRITE:
  - rxwready = 1.
  - Each W handshake drives sram_select = 1, sram_wenable = 1 in the same cycle, with sram_byteenable = rxwstrb and sram_wdata = rxwdata.
  - The burst ends on beat len+1, whatever rxwlast says.
  - rxwlast missing on the final beat, or asserted on an earlier beat: bresp = SLVERR.
  - Go to WRESP after the final beat.
- WRESP: rxbvalid = 1 with latched id/resp. On rxbvalid & rxbready go to IDLE; a new address is accepted no earlier than the next cycle.
- READ:
  - 2-entry output FIFO, plus one in-flight SRAM read.
  - Issue a read (sram_select = 1, sram_wenable = 0) when fifo_count + inflight < 2 and beats remain.
  - sram_rdata is pushed into the FIFO the following cycle.
  - R outputs come from the FIFO head. rxrlast = 1 on beat len. rxrid = latched id.
  - Minimum latency: AR handshake in cycle N, first rxrvalid in N+2.
  - With rxrready held 1, throughput is 1 beat/cycle with no bubbles.
  - Once all beats are issued, go to RDRAIN.
- RDRAIN: go to IDLE on the handshake of the rlast beat.
- rxrvalid/rxbvalid never drop before their handshake; payload is stable while valid & ~ready.
- len = 255 is legal. The beat counter is 9 bits; counter wrap is never reached.
- SRAM address wraps modulo 2^BW_SRAM_ADDR; no decode error.
- Reset mid-burst: immediately return to IDLE, flush the FIFO, drop any in-flight read; no response is issued for the aborted transaction.

Test Plan:
- Single write: AW addr 0x10, len 0, size 2, INCR; W data 0xDEADBEEF, strb 0xF, wlast 1 -> sram write at word 4, then bresp OKAY, rxbid = awid.
- INCR read: AR addr 0x10, len 3, rxrready = 1 -> rdata words 4..7 on consecutive cycles; rvalid first in cycle N+2; rlast on beat 3 only.
- Backpressure: same read with rxrready toggling 1,0,0,1 -> no beat lost or duplicated; FIFO never exceeds 2; data stable while stalled.
- WRAP: AR addr 0x18, len 3, size 2, WRAP -> word order 6, 7, 4, 5.
- Arbitration: rxawvalid and rxarvalid asserted together twice in a row -> first grant read (reset pointer), second grant write.
- Errors: AW burst 2'b11 -> no sram_select, bresp SLVERR. Write len 1 with wlast on beat 0 -> bresp SLVERR. rstnn low mid-read -> all valids 0 next edge, FSM in IDLE.
